cfg_pll: RTL and testbench

- Synthesizable clock-generation and lock-indication block. It models a single-output PLL: one reference clock in (clkin1, nominal 27 MHz), one derived clock out (clkout0), one lock flag.
- clkout0 is clkin1 divided by an even integer, with an optional phase offset and optional gating until lock.
- Sits at the top-level clocking front end. Downstream logic holds itself in reset until lock is high.

---
 rtl/cfg_pll.sv | 164 ++++++++++++++++
 tb/tb_cfg_pll.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_pll.sv
`default_nettype none
// ============================================================================
// Module   : cfg_pll
// Purpose  : Single-output clock generator with lock indication. clkout0 is
//            clkin1 divided by an even ratio, optionally delayed by a whole
//            number of clkin1 cycles and optionally held low until lock.
//            lock asserts a fixed number of clkin1 edges after reset release
//            and stays high until the next reset.
// Ports    : clkin1  - reference clock, all logic on its rising edge
//            rst     - synchronous active-high reset
//            clkout0 - divided clock, 50% duty, register-driven
//            lock    - sticky lock flag, register-driven
// Revision : 1.0 - initial release
// ============================================================================
module cfg_pll #(
  parameter real CLKIN_FREQ    = 27.0,  // MHz, informational only
  parameter int  CLKOUT0_DIV   = 2,
  parameter int  CLKOUT0_PHASE = 0,
  parameter int  CLKOUT0_GATE  = 0,
  parameter int  LOCK_CYCLES   = 1024
) (
  input  logic clkin1,
  input  logic rst,
  output logic clkout0,
  output logic lock
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if ((CLKOUT0_DIV < 2) || (CLKOUT0_DIV > 256) || ((CLKOUT0_DIV % 2) != 0)) begin : g_bad_div
      $error("cfg_pll: CLKOUT0_DIV must be even and within 2..256");
    end
    if ((CLKOUT0_PHASE < 0) || (CLKOUT0_PHASE > CLKOUT0_DIV - 1)) begin : g_bad_phase
      $error("cfg_pll: CLKOUT0_PHASE must be within 0..CLKOUT0_DIV-1");
    end
    if ((CLKOUT0_GATE != 0) && (CLKOUT0_GATE != 1)) begin : g_bad_gate
      $error("cfg_pll: CLKOUT0_GATE must be 0 or 1");
    end
    if ((LOCK_CYCLES < 1) || (LOCK_CYCLES > 65535)) begin : g_bad_lock
      $error("cfg_pll: LOCK_CYCLES must be within 1..65535");
    end
    if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
      $error("cfg_pll: CLKIN_FREQ must be positive");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_half           = CLKOUT0_DIV / 2;
  localparam logic [7:0] c_half_m1        = 8'(c_half - 1);
  localparam logic [8:0] c_phase          = 9'(CLKOUT0_PHASE);
  localparam logic [15:0] c_lock_cycles   = 16'(LOCK_CYCLES);
  // With no phase offset the divider is free to start on the first edge.
  localparam logic       c_phase_done_rst = (CLKOUT0_PHASE > 0) ? 1'b0 : 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [8:0]  phase_cnt_q, phase_cnt_d;
  logic        phase_done_q, phase_done_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        div_clk_q, div_clk_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        lock_q, lock_d;
  logic        clkout_q, clkout_d;

  // --------------------------------------------------------------------------
  // Next-state logic: phase delay, divider and lock counter
  // --------------------------------------------------------------------------
  always_comb begin
    phase_cnt_d  = phase_cnt_q;
    phase_done_d = phase_done_q;
    div_cnt_d    = div_cnt_q;
    div_clk_d    = div_clk_q;

    // Phase stage: count edges until the offset is reached, then release
    // the divider on the following edge.
    if (!phase_done_q) begin
      phase_cnt_d = phase_cnt_q + 9'd1;
      if (phase_cnt_d == c_phase) begin
        phase_done_d = 1'b1;
      end
    end

    // Divider: toggle every half period.
    if (phase_done_q) begin
      if (div_cnt_q == c_half_m1) begin
        div_cnt_d = 8'd0;
        div_clk_d = ~div_clk_q;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end

    // Lock counter saturates at the terminal count so lock can never
    // re-evaluate to zero on its own.
    if (lock_cnt_q == c_lock_cycles) begin
      lock_cnt_d = lock_cnt_q;
    end else begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end
    lock_d = lock_q | (lock_cnt_d == c_lock_cycles);
  end

  // --------------------------------------------------------------------------
  // Output clock path
  // --------------------------------------------------------------------------
  generate
    if (CLKOUT0_GATE != 0) begin : g_gate
      logic gate_en_q, gate_en_d;

      // The gate only opens on an internal rising transition that occurs
      // while lock is already high, so the first visible high phase is
      // always a full half period.
      always_comb begin
        gate_en_d = gate_en_q | (lock_q & ~div_clk_q & div_clk_d);
        clkout_d  = div_clk_d & gate_en_d;
      end

      always_ff @(posedge clkin1) begin
        if (rst) begin
          gate_en_q <= 1'b0;
        end else begin
          gate_en_q <= gate_en_d;
        end
      end
    end else begin : g_free
      always_comb begin
        clkout_d = div_clk_d;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin1) begin
    if (rst) begin
      phase_cnt_q  <= 9'd0;
      phase_done_q <= c_phase_done_rst;
      div_cnt_q    <= 8'd0;
      div_clk_q    <= 1'b0;
      lock_cnt_q   <= 16'd0;
      lock_q       <= 1'b0;
      clkout_q     <= 1'b0;
    end else begin
      phase_cnt_q  <= phase_cnt_d;
      phase_done_q <= phase_done_d;
      div_cnt_q    <= div_cnt_d;
      div_clk_q    <= div_clk_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_q       <= lock_d;
      clkout_q     <= clkout_d;
    end
  end

  assign clkout0 = clkout_q;
  assign lock    = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_pll.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cfg_pll
// Purpose  : Self-checking bench for cfg_pll across several parameter sets.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_pll;

  localparam int NI = 6;
  // Per-instance parameters: phase, half period, gate, lock cycles.
  localparam int P_T  [NI] = '{0, 0, 3, 0, 5, 255};
  localparam int H_T  [NI] = '{1, 4, 4, 2, 3, 128};
  localparam int G_T  [NI] = '{0, 0, 0, 1, 1, 0};
  localparam int LK_T [NI] = '{1024, 1024, 1024, 16, 1, 300};

  logic       clkin1 = 1'b0;
  logic       rst    = 1'b1;
  logic [NI-1:0] clk_w;
  logic [NI-1:0] lock_w;
  int n = 0;          // clkin1 edges since reset release
  int total = 0;
  int bad = 0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;

  always #18.518 clkin1 = ~clkin1;   // ~27 MHz

  always @(posedge clkin1) begin
    if (rst) n <= 0;
    else     n <= n + 1;
    s1 <= lock_w[0];
    s2 <= s1;
    s3 <= s2;
  end

  cfg_pll u_def (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[0]), .lock(lock_w[0]));

  cfg_pll #(.CLKOUT0_DIV(8)) u_d8
    (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[1]), .lock(lock_w[1]));

  cfg_pll #(.CLKOUT0_DIV(8), .CLKOUT0_PHASE(3)) u_d8p3
    (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[2]), .lock(lock_w[2]));

  cfg_pll #(.CLKOUT0_DIV(4), .CLKOUT0_GATE(1), .LOCK_CYCLES(16)) u_gate
    (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[3]), .lock(lock_w[3]));

  cfg_pll #(.CLKOUT0_DIV(6), .CLKOUT0_PHASE(5), .CLKOUT0_GATE(1), .LOCK_CYCLES(1)) u_l1
    (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[4]), .lock(lock_w[4]));

  cfg_pll #(.CLKOUT0_DIV(256), .CLKOUT0_PHASE(255), .LOCK_CYCLES(300)) u_d256
    (.clkin1(clkin1), .rst(rst), .clkout0(clk_w[5]), .lock(lock_w[5]));

  // Expected clkout0 after k edges since release: high for the first half of
  // each period starting at edge P+H; gated outputs only show periods whose
  // rising edge comes after the edge where lock rose.
  function automatic logic exp_clk(input int i, input int k);
    int p, h, rise;
    p = P_T[i];
    h = H_T[i];
    if (k < p + h) return 1'b0;
    if ((((k - p - h) / h) % 2) != 0) return 1'b0;
    if (G_T[i] == 0) return 1'b1;
    rise = p + h + 2 * h * ((k - p - h) / (2 * h));
    return (rise - 1 >= LK_T[i]);
  endfunction

  function automatic logic exp_lock(input int i, input int k);
    return (k >= LK_T[i]);
  endfunction

  task automatic tick();
    @(posedge clkin1);
    @(negedge clkin1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (clk_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_clk inst=%0d got=%b exp=0", i, clk_w[i]);
      end
      total++;
      if (lock_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_lock inst=%0d got=%b exp=0", i, lock_w[i]);
      end
    end
  endtask

  task automatic test_lock_default();
    logic s3_prev;
    do_reset(3);
    s3_prev = s3;
    for (int c = 0; c < 1351; c++) begin
      tick();
      total++;
      if (lock_w[0] !== exp_lock(0, n)) begin
        bad++;
        $display("FAIL lock_def n=%0d got=%b exp=%b", n, lock_w[0], exp_lock(0, n));
      end
      total++;
      if (s3_prev === 1'b1 && s3 !== 1'b1) begin
        bad++;
        $display("FAIL lock_sync_fall n=%0d got=%b exp=1", n, s3);
      end
      s3_prev = s3;
      for (int i = 5; i < NI; i++) begin
        total++;
        if (clk_w[i] !== exp_clk(i, n) || lock_w[i] !== exp_lock(i, n)) begin
          bad++;
          $display("FAIL d256 n=%0d got=%b/%b exp=%b/%b", n, clk_w[i], lock_w[i],
                   exp_clk(i, n), exp_lock(i, n));
        end
      end
    end
    total++;
    if (lock_w[0] !== 1'b1 || $realtime < 50000.0) begin
      bad++;
      $display("FAIL lock_50us t=%0t got=%b exp=1", $time, lock_w[0]);
    end
  endtask

  task automatic test_divide();
    int fr[2];
    fr = '{-1, -1};
    do_reset(2);
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (clk_w[i] !== exp_clk(i, n)) begin
          bad++;
          $display("FAIL divide inst=%0d n=%0d got=%b exp=%b", i, n, clk_w[i], exp_clk(i, n));
        end
        if (fr[i] < 0 && clk_w[i] === 1'b1) fr[i] = n;
      end
    end
    total++;
    if (fr[0] != 1) begin
      bad++;
      $display("FAIL first_rise_div2 got=%0d exp=1", fr[0]);
    end
    total++;
    if (fr[1] != 4) begin
      bad++;
      $display("FAIL first_rise_div8 got=%0d exp=4", fr[1]);
    end
  endtask

  task automatic test_phase();
    int fr;
    fr = -1;
    do_reset(2);
    for (int c = 0; c < 60; c++) begin
      tick();
      total++;
      if (clk_w[2] !== exp_clk(2, n)) begin
        bad++;
        $display("FAIL phase n=%0d got=%b exp=%b", n, clk_w[2], exp_clk(2, n));
      end
      if (n >= 3) begin
        total++;
        if (clk_w[2] !== exp_clk(1, n - 3)) begin
          bad++;
          $display("FAIL phase_shift n=%0d got=%b exp=%b", n, clk_w[2], exp_clk(1, n - 3));
        end
      end
      if (fr < 0 && clk_w[2] === 1'b1) fr = n;
    end
    total++;
    if (fr != 7) begin
      bad++;
      $display("FAIL first_rise_phase3 got=%0d exp=7", fr);
    end
  endtask

  task automatic test_mid_reset();
    int waited;
    do_reset(2);
    waited = 0;
    while (lock_w[0] !== 1'b1 && waited < 1100) begin
      tick();
      waited++;
    end
    total++;
    if (lock_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_lock_wait got=%b exp=1", lock_w[0]);
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (clk_w[i] !== 1'b0 || lock_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL mid_rst inst=%0d got=%b/%b exp=0/0", i, clk_w[i], lock_w[i]);
      end
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1030; c++) begin
      tick();
      total++;
      if (lock_w[0] !== exp_lock(0, n)) begin
        bad++;
        $display("FAIL mid_relock n=%0d got=%b exp=%b", n, lock_w[0], exp_lock(0, n));
      end
    end
  endtask

  task automatic test_gate();
    int first_len;
    bit seen;
    first_len = 0;
    seen = 1'b0;
    do_reset(2);
    for (int c = 0; c < 40; c++) begin
      tick();
      total++;
      if (clk_w[3] !== exp_clk(3, n) || lock_w[3] !== exp_lock(3, n)) begin
        bad++;
        $display("FAIL gate n=%0d got=%b/%b exp=%b/%b", n, clk_w[3], lock_w[3],
                 exp_clk(3, n), exp_lock(3, n));
      end
      if (lock_w[3] !== 1'b1) begin
        total++;
        if (clk_w[3] !== 1'b0) begin
          bad++;
          $display("FAIL gate_prelock n=%0d got=%b exp=0", n, clk_w[3]);
        end
      end
      if (clk_w[3] === 1'b1 && (!seen || first_len > 0) && first_len >= 0) begin
        seen = 1'b1;
        first_len++;
      end else if (seen && first_len > 0) begin
        total++;
        if (first_len != 2) begin
          bad++;
          $display("FAIL gate_first_pulse got=%0d exp=2", first_len);
        end
        first_len = -1;
      end
    end
    total++;
    if (first_len != -1) begin
      bad++;
      $display("FAIL gate_pulse_seen got=%0d exp=-1", first_len);
    end
  endtask

  task automatic test_lock1();
    rst = 1'b1;
    tick();
    total++;
    if (lock_w[4] !== 1'b0) begin
      bad++;
      $display("FAIL lock1_held got=%b exp=0", lock_w[4]);
    end
    rst = 1'b0;
    tick();
    total++;
    if (lock_w[4] !== 1'b1 || n != 1) begin
      bad++;
      $display("FAIL lock1_first n=%0d got=%b exp=1", n, lock_w[4]);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) < 3);
      tick();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (clk_w[i] !== exp_clk(i, n) || lock_w[i] !== exp_lock(i, n)) begin
          bad++;
          $display("FAIL random inst=%0d n=%0d got=%b/%b exp=%b/%b", i, n, clk_w[i],
                   lock_w[i], exp_clk(i, n), exp_lock(i, n));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lock_default();
    test_divide();
    test_phase();
    test_mid_reset();
    test_gate();
    test_lock1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
